// File: rtl/sample_cmp_tracker.sv
// Windowed sample tracker: per window of WINDOW accepted samples, reports max/min and
// how many samples rose, fell or held relative to their predecessor, via a valid/ready result port.
module sample_cmp_tracker #(
   parameter int WIDTH  = 4,
   parameter int WINDOW = 4,
   localparam int CW    = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [CW-1:0]    out_rise,
   output logic [CW-1:0]    out_fall,
   output logic [CW-1:0]    out_hold
);

   typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   state_t           state, state_n;
   logic             accept;
   logic [WIDTH-1:0] max_r, min_r, prev_r;
   logic [CW-1:0]    rise_r, fall_r, hold_r, cnt_r;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = (WINDOW == 1) ? REPORT : TRACK;
         TRACK:   if (accept && cnt_r == LAST) state_n = REPORT;
         REPORT:  if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // An abort wins over any accept or handshake on the same edge.
      if (clr) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_r  <= '0;
         min_r  <= '0;
         prev_r <= '0;
         rise_r <= '0;
         fall_r <= '0;
         hold_r <= '0;
         cnt_r  <= '0;
      end else if (clr) begin
         max_r  <= '0;
         min_r  <= '0;
         prev_r <= '0;
         rise_r <= '0;
         fall_r <= '0;
         hold_r <= '0;
         cnt_r  <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            max_r  <= in_data;
            min_r  <= in_data;
            prev_r <= in_data;
            rise_r <= '0;
            fall_r <= '0;
            hold_r <= '0;
            cnt_r  <= CW'(1);
         end else begin
            if (in_data > prev_r)      rise_r <= rise_r + CW'(1);
            else if (in_data < prev_r) fall_r <= fall_r + CW'(1);
            else                       hold_r <= hold_r + CW'(1);
            if (in_data > max_r) max_r <= in_data;
            if (in_data < min_r) min_r <= in_data;
            prev_r <= in_data;
            cnt_r  <= cnt_r + CW'(1);
         end
      end
   end

   // Result fields are only visible while a report is presented.
   assign in_ready  = (state != REPORT);
   assign out_valid = (state == REPORT);
   assign out_max   = out_valid ? max_r  : '0;
   assign out_min   = out_valid ? min_r  : '0;
   assign out_rise  = out_valid ? rise_r : '0;
   assign out_fall  = out_valid ? fall_r : '0;
   assign out_hold  = out_valid ? hold_r : '0;

endmodule

// File: tb/tb_sample_cmp_tracker.sv
// Bench for sample_cmp_tracker: directed windows with literal expectations plus a
// queue-based window model compared against the DUT on every falling edge.
module tb_sample_cmp_tracker;

   localparam int WIDTH  = 4;
   localparam int WINDOW = 4;
   localparam int CW     = $clog2(WINDOW + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_max, out_min;
   logic [CW-1:0]    out_rise, out_fall, out_hold;

   int checks = 0;
   int failures = 0;

   sample_cmp_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_min(out_min),
      .out_rise(out_rise), .out_fall(out_fall), .out_hold(out_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: samples of the open window in a queue, one pending result.
   int   q[$];
   bit   m_rep = 0;
   int   m_max = 0, m_min = 0, m_rise = 0, m_fall = 0, m_hold = 0;
   int   m_done = 0;

   function automatic void close_window();
      m_max = q[0]; m_min = q[0]; m_rise = 0; m_fall = 0; m_hold = 0;
      for (int i = 1; i < q.size(); i++) begin
         if (q[i] > m_max) m_max = q[i];
         if (q[i] < m_min) m_min = q[i];
         if (q[i] > q[i-1])      m_rise++;
         else if (q[i] < q[i-1]) m_fall++;
         else                    m_hold++;
      end
      q.delete();
      m_rep = 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_rep = 0;
      end else if (clr) begin
         q.delete();
         m_rep = 0;
      end else if (m_rep) begin
         if (out_ready) begin
            m_rep = 0;
            m_done++;
         end
      end else if (in_valid) begin
         q.push_back(int'(in_data));
         if (q.size() == WINDOW) close_window();
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, !m_rep);
      chk("out_valid", out_valid, m_rep);
      chk("out_max", out_max, m_rep ? m_max : 0);
      chk("out_min", out_min, m_rep ? m_min : 0);
      chk("out_rise", out_rise, m_rep ? m_rise : 0);
      chk("out_fall", out_fall, m_rep ? m_fall : 0);
      chk("out_hold", out_hold, m_rep ? m_hold : 0);
      if (out_valid) chk("count_sum", out_rise + out_fall + out_hold, WINDOW - 1);
   end

   task automatic feed(input logic [WIDTH-1:0] s);
      in_valid = 1'b1;
      in_data  = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_result(input string nm, input int mx, input int mn,
                                input int r, input int f, input int h);
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_max"}, out_max, mx);
      chk({nm, "_min"}, out_min, mn);
      chk({nm, "_rise"}, out_rise, r);
      chk({nm, "_fall"}, out_fall, f);
      chk({nm, "_hold"}, out_hold, h);
   endtask

   initial begin
      int base;
      bit reached;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_max", out_max, 0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // Mixed rise/fall window, consumer always ready.
      out_ready = 1'b1;
      feed(4'b0001); feed(4'b0010); feed(4'b1010); feed(4'b0011);
      expect_result("mixed", 10, 1, 2, 1, 0);
      chk("mixed_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("mixed_after_valid", out_valid, 0);
      chk("mixed_after_ready", in_ready, 1);

      // All samples equal.
      feed(4'b0110); feed(4'b0110); feed(4'b0110); feed(4'b0110);
      expect_result("equal", 6, 6, 0, 0, 3);
      @(posedge clk); #1;

      // Extremes with a stalled consumer and a pushy producer.
      out_ready = 1'b0;
      feed(4'b1111); feed(4'b0000); feed(4'b1111); feed(4'b1110);
      in_valid = 1'b1; in_data = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         expect_result("stall", 15, 0, 1, 2, 0);
         chk("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_valid", out_valid, 0);
      chk("stall_release_ready", in_ready, 1);

      // Reset mid-window, then reset while a report is held.
      feed(4'b0011); feed(4'b0100);
      rst_n = 1'b0; #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      feed(4'b0001); feed(4'b0001); feed(4'b0001); feed(4'b0010);
      expect_result("postrst", 2, 1, 1, 0, 2);
      rst_n = 1'b0; #1;
      chk("rptrst_out_valid", out_valid, 0);
      chk("rptrst_out_max", out_max, 0);
      chk("rptrst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Abort of a presented result on the handshake cycle.
      feed(4'b1000); feed(4'b0100); feed(4'b0010); feed(4'b0001);
      expect_result("preclr", 8, 1, 0, 3, 0);
      base = m_done;
      clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_out_valid", out_valid, 0);
      chk("clr_in_ready", in_ready, 1);
      chk("clr_not_delivered", m_done - base, 0);

      // Abort mid-window with a simultaneous sample, then a fresh window.
      feed(4'b0111); feed(4'b0111);
      clr = 1'b1; in_valid = 1'b1; in_data = 4'b1111;
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      feed(4'b0010); feed(4'b0011); feed(4'b0011); feed(4'b0001);
      expect_result("afterclr", 3, 1, 1, 1, 1);
      @(posedge clk); #1;

      // Random windows with random gaps, stalls and rare aborts.
      base = m_done;
      reached = 0;
      for (int c = 0; c < 60000; c++) begin
         if (m_done - base >= 1000) begin
            reached = 1;
            break;
         end
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = WIDTH'($urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         clr       = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; clr = 1'b0;
      chk("random_windows_done", reached, 1);

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_cmp_tracker.md
SAMPLE_CMP_TRACKER -- requirements
Module: sample_cmp_tracker

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits, unsigned.
REQ-002 Parameter: WINDOW, default 4, samples per report window, legal range >= 1.
REQ-003 Derived: CW = $clog2(WINDOW+1), width of every count output.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous abort of the current window or report.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_data  input  WIDTH  sample to be tracked.
REQ-009 in_ready  output  1  block can accept a sample this cycle.
REQ-010 out_valid  output  1  window result is presented.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_max, out_min  output  WIDTH each  largest and smallest sample in the window.
REQ-013 out_rise, out_fall, out_hold  output  CW each  counts of samples gt / lt / eq to the previous sample in the same window.

Function
REQ-014 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; in_data on all other cycles SHALL be ignored.
REQ-015 FSM states SHALL be IDLE (no sample in window), TRACK (1..WINDOW-1 samples accepted) and REPORT (result held).
REQ-016 IDLE, accept: max=min=prev=sample, all counts=0, sample count=1; next state TRACK, or REPORT if WINDOW=1.
REQ-017 TRACK, accept: compare the sample with prev unsigned; increment exactly one of rise (gt), fall (lt), hold (eq); update max/min; prev=sample.
REQ-018 TRACK SHALL go to REPORT on the accept that brings the sample count to WINDOW; out_valid SHALL assert the cycle after that accept (latency 1).
REQ-019 in_ready SHALL be 1 in IDLE and TRACK and 0 in REPORT.
REQ-020 In REPORT, all out_* data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 REPORT with out_ready=1 SHALL complete the handshake; next state IDLE, out_valid=0 and in_ready=1 on the following cycle.
REQ-022 A sample cannot be accepted on the handshake cycle, because in_ready=0 in REPORT.
REQ-023 rise+fall+hold SHALL equal WINDOW-1 whenever out_valid=1.
REQ-024 clr=1 SHALL force IDLE on the next edge from any state, with out_valid=0 and counts/max/min cleared to 0.
REQ-025 clr SHALL take priority over a simultaneous sample accept or output handshake; that sample or result is discarded.
REQ-026 Equal max candidates, including all samples equal, SHALL give out_max=out_min=that value; no signed interpretation.
REQ-027 Counts SHALL never wrap; CW covers WINDOW-1.
REQ-028 Outside REPORT, out_max/out_min/out_rise/out_fall/out_hold SHALL read 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, out_valid=0, in_ready=1 and all data, count and prev registers to 0.
REQ-030 Reset asserted mid-window SHALL discard all partial window state; the first accept after release starts a fresh window.
REQ-031 Release of rst_n SHALL need no clock cycles of settling; the first accept is possible on the first edge after release.

Verification (WIDTH=4, WINDOW=4)
REQ-032 Samples 0001,0010,1010,0011 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th accept; max=1010, min=0001, rise=2, fall=1, hold=0.
REQ-033 Samples 0110 x4 -> max=min=0110, rise=0, fall=0, hold=3.
REQ-034 Samples 1111,0000,1111,1110, then out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0; outputs stable at max=1111, min=0000, rise=1, fall=2, hold=0; no samples accepted; raise out_ready -> IDLE next cycle.
REQ-035 rst_n pulsed low after 2 accepted samples -> outputs 0 immediately; then 0001,0001,0001,0010 -> max=0010, min=0001, rise=1, hold=2.
REQ-036 clr=1 in REPORT with out_ready=1 on the same cycle -> out_valid=0 and in_ready=1 on the next cycle; the result is not counted as delivered.
REQ-037 Scoreboard: a reference model computes max/min/rise/fall/hold per window; 1000 random windows with random in_valid/out_ready gaps SHALL match and satisfy REQ-023.
